// File: rtl/pipeline_types.sv
// Shared front-end pipeline types: fetch state encoding and boot address.
package pipeline_types;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    IDLE = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator: icache request path plus BPU prediction.
interface pc_gen_if;
  logic             icache_ready;
  logic [1:0][31:0] pc_o;
  logic [1:0]       fetch_inst_en;
  logic [1:0]       adef;
  logic [1:0]       pre_taken_or_not;
  logic [31:0]      pre_branch_addr;

  modport master (
    input  icache_ready, pre_taken_or_not, pre_branch_addr,
    output pc_o, fetch_inst_en, adef
  );

  modport slave (
    output icache_ready, pre_taken_or_not, pre_branch_addr,
    input  pc_o, fetch_inst_en, adef
  );
endinterface

// File: rtl/pc_gen.sv
// Two-wide fetch PC generator: boots at RESET_PC, follows BPU predictions,
// takes exception/mispredict redirects with a one-cycle bubble, parks on IDLE.
module pc_gen
  import pipeline_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pause,
  input  logic        excp_flush,
  input  logic [31:0] excp_entry,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        idle_en,
  pc_gen_if.master    fetch
);

  pc_state_e   state;
  pc_state_e   state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic        adv;
  logic [1:0]  fetch_en;
  logic [1:0]  adef_int;

  assign pc_plus4 = pc_reg + INST_BYTES;
  assign pc_plus8 = pc_reg + (INST_BYTES << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // idle_en is dropped whenever a redirect lands in the same cycle
  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     if (!excp_flush && !flush && idle_en) state_next = IDLE;
      IDLE:    if (excp_flush) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    adv         = (state == RUN) & fetch.icache_ready & ~stall & ~pause & ~flush & ~excp_flush;
    fetch_en[0] = adv;
    fetch_en[1] = adv & ~pc_reg[2] & ~fetch.pre_taken_or_not[0];
    adef_int[0] = fetch_en[0] & (pc_reg[1:0] != 2'b00);
    adef_int[1] = fetch_en[1] & (pc_plus4[1:0] != 2'b00);
  end

  // Slot 1 only exists on an 8-byte-aligned pair, so an odd-word pc steps by 4
  always_comb begin
    pc_next = pc_reg;
    if (excp_flush) begin
      pc_next = excp_entry;
    end else if (flush && (state == RUN)) begin
      pc_next = flush_target;
    end else if (adv) begin
      if (fetch.pre_taken_or_not[0])                      pc_next = fetch.pre_branch_addr;
      else if (fetch_en[1] && fetch.pre_taken_or_not[1])  pc_next = fetch.pre_branch_addr;
      else if (pc_reg[2])                                 pc_next = pc_plus4;
      else                                                pc_next = pc_plus8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= RESET_PC;
    else        pc_reg <= pc_next;
  end

  assign fetch.pc_o          = {pc_plus4, pc_reg};
  assign fetch.fetch_inst_en = fetch_en;
  assign fetch.adef          = adef_int;

endmodule
